// File: rtl/sipo_pkg.sv
// sipo_pkg
// Shared definitions for the sine-wave sample link deserializer.
//   state_t   : receiver FSM states (IDLE hunting for SYNC, SHIFT mid-word)
//   cntWidth  : width of the bit counter for a given MSB index N
//   PAR_BITS  : number of trailing parity bits per frame
// Optional feature macro: SIPO_PARITY_EN (adds one even-parity bit per frame).
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The counter must reach N+1 when a parity bit follows the data bits.
  function automatic int cntWidth(input int n);
    return $clog2(n + 2);
  endfunction

`ifdef SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf
// One-entry valid/ready holding register between the receiver and the
// downstream sample consumer.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   word     : completed word to load (W bits)
//   wr       : a word completed this cycle
//   ready    : consumer accepts data when valid & ready
//   data     : registered output word, RST_VAL after reset
//   valid    : data holds an unconsumed word
//   drop     : wr arrived while the buffer is full and not being emptied
module sipo_out_buf #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] word,
  input  logic         wr,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         drop
);

  logic canLoad;

  // A slot being emptied this cycle can take the new word in the same edge.
  assign canLoad = !valid || ready;
  assign drop    = wr && !canLoad;

  // Load on a completed word when there is room; otherwise a consumed word
  // empties the slot. data is untouched while valid & !ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= RST_VAL;
      valid <= 1'b0;
    end else if (wr && canLoad) begin
      data  <= word;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in/parallel-out receiver, receive end of the PISO serializer.
// Words arrive MSB first, one bit per clk with CE=1; SYNC (qualified by CE)
// marks the first bit of each word.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   SI       : serial data, sampled when CE=1
//   CE       : bit enable
//   SYNC     : first-bit marker
//   PDATA    : assembled word (N+1 bits), registered
//   PVALID   : PDATA holds an unconsumed word
//   PREADY   : consumer accepts PDATA when PVALID & PREADY
//   BUSY     : a word is partially received
//   OVERRUN  : sticky, a completed word was dropped
//   CLR_OVR  : synchronous clear of OVERRUN (a same-cycle drop wins)
//   PERR     : parity mismatch for the word in PDATA (SIPO_PARITY_EN only)
// Optional feature macro: SIPO_PARITY_EN.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int           N        = 7,
  parameter logic [N:0]   RST_DATA = {(N+1){1'b0}}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SI,
  input  logic       CE,
  input  logic       SYNC,
  output logic [N:0] PDATA,
  output logic       PVALID,
  input  logic       PREADY,
  output logic       BUSY,
  output logic       OVERRUN,
`ifdef SIPO_PARITY_EN
  output logic       PERR,
`endif
  input  logic       CLR_OVR
);

  localparam int CW = cntWidth(N);
  // Without parity the last data bit goes straight to the buffer, so the
  // shift register only needs N bits; with parity it holds the full word.
  localparam int SW = N + PAR_BITS;
  localparam int BW = N + 1 + PAR_BITS;
  localparam logic [CW-1:0] LAST = CW'(N + PAR_BITS);

`ifdef SIPO_PARITY_EN
  localparam logic [BW-1:0] BUF_RST = {1'b0, RST_DATA};
`else
  localparam logic [BW-1:0] BUF_RST = RST_DATA;
`endif

  state_t        state, nextState;
  logic [CW-1:0] cnt, cntNext;
  logic [SW-1:0] sreg, sregNext;
  logic          wr;
  logic          drop;
  logic [BW-1:0] bufWord;
  logic [BW-1:0] bufData;

  // FSM, counter and shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      sreg  <= sregNext;
    end
  end

  // SYNC restarts a word from either state, discarding any partial word.
  // Plain bits are only taken inside a word; in IDLE they are ignored.
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    sregNext  = sreg;
    wr        = 1'b0;
    if (CE) begin
      if (SYNC) begin
        sregNext  = {sreg[SW-2:0], SI};
        cntNext   = CW'(1);
        nextState = SHIFT;
      end else if (state == SHIFT) begin
        if (cnt == LAST) begin
          wr        = 1'b1;
          cntNext   = '0;
          nextState = IDLE;
`ifndef SIPO_PARITY_EN
          sregNext  = {sreg[SW-2:0], SI};
`endif
        end else begin
          sregNext = {sreg[SW-2:0], SI};
          cntNext  = cnt + CW'(1);
        end
      end
    end
  end

  // With parity the final SI is the parity bit, not data; a mismatch is
  // flagged when the data bits and the parity bit together have odd weight.
`ifdef SIPO_PARITY_EN
  assign bufWord = {^{sreg, SI}, sreg};
`else
  assign bufWord = {sreg, SI};
`endif

  sipo_out_buf #(
    .W      (BW),
    .RST_VAL(BUF_RST)
  ) u_out_buf (
    .clk  (clk),
    .rst  (rst),
    .word (bufWord),
    .wr   (wr),
    .ready(PREADY),
    .data (bufData),
    .valid(PVALID),
    .drop (drop)
  );

`ifdef SIPO_PARITY_EN
  assign PDATA = bufData[N:0];
  assign PERR  = bufData[N+1];
`else
  assign PDATA = bufData;
`endif

  assign BUSY = (state == SHIFT);

  // Sticky overrun: a drop in the same cycle as CLR_OVR keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OVERRUN <= 1'b0;
    end else if (drop) begin
      OVERRUN <= 1'b1;
    end else if (CLR_OVR) begin
      OVERRUN <= 1'b0;
    end
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver for the sine-wave sample link; it is the receive end of the PISO serializer.
- Words arrive MSB first, one bit per enabled clock; a SYNC strobe marks each word's first bit.
- Assembled words go out through a one-entry valid/ready output buffer to the downstream sample consumer.
- An overrun flag records words lost to back-pressure.

Parameters:
- N, 7, MSB index; word width is N+1, same convention as the serializer.
- RST_DATA, {(N+1){1'b0}}, reset value of PDATA.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- SI  input  1  serial data in; sampled only when CE=1.
- CE  input  1  bit enable; one serial bit per clk with CE=1.
- SYNC  input  1  first-bit marker; qualified by CE.
- PDATA  output  N+1  assembled word, registered.
- PVALID  output  1  PDATA holds an unconsumed word.
- PREADY  input  1  consumer accepts PDATA when PVALID&PREADY.
- BUSY  output  1  a word is partially received (state SHIFT).
- OVERRUN  output  1  sticky; a completed word was dropped.
- CLR_OVR  input  1  synchronous clear of OVERRUN.

Behaviour:
- Reset (async, any time, including mid-word):
  - state=IDLE, bit counter=0, shift reg=0.
  - PDATA=RST_DATA, PVALID=0, BUSY=0, OVERRUN=0.
  - A partial word is discarded.
- Shift rule: on a capture, sreg <= {sreg[N-1:0], SI}. The first captured bit ends in PDATA[N].
- IDLE:
  - CE=1 & SYNC=1 → capture SI, cnt=1, go SHIFT.
  - CE=1 & SYNC=0 → bit ignored (hunting for frame start).
  - CE=0 → hold.
- SHIFT:
  - CE=0 → hold all state (CE gaps of any length are allowed).
  - CE=1 & SYNC=1 → resync: partial word discarded, capture SI as new MSB, cnt=1, stay SHIFT.
  - CE=1 & SYNC=0 & cnt<N → capture, cnt++.
  - CE=1 & SYNC=0 & cnt==N → capture the last bit (LSB) and the word is complete; go IDLE.
- Word completion:
  - Completed word = {sreg[N-1:0], SI}.
  - Buffer free, or being emptied this cycle (PVALID=0 or PREADY=1) → PDATA<=word, PVALID<=1 on the next edge.
  - Buffer full and not being emptied (PVALID=1 & PREADY=0) → word dropped, PDATA unchanged, OVERRUN<=1.
- Latency: PVALID rises on the edge of the CE cycle that samples the LSB. Minimum word period is N+1 clks.
- Handshake:
  - PVALID&PREADY → transfer; PVALID falls next cycle unless a new word completes in the same cycle.
  - PDATA is stable while PVALID=1 and PREADY=0.
- Back-to-back framing: SYNC with CE in the cycle after the LSB starts the next word with no gap.
- OVERRUN:
  - Set has priority over CLR_OVR when both occur in the same cycle.
  - Otherwise CLR_OVR=1 clears it.
- BUSY = (state==SHIFT). Counter width = $clog2(N+2).

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Frame is N+2 bits: the N+1 data bits, then one even-parity bit (XOR of data bits).
  - Completion moves to cnt==N+1, and the parity bit is not shifted into sreg.
  - Adds output PERR (1 bit), registered and loaded together with PDATA; it is 1 when parity mismatches.
  - The word is still delivered when PERR=1. A dropped word does not update PERR.
- Undefined: no PERR port; frame is N+1 bits.

Decomposition:
- Package sipo_pkg holds:
  - state enum {IDLE, SHIFT};
  - localparam function for counter width;
  - parity-bit-count constant selected by SIPO_PARITY_EN.
- One sub-module, sipo_out_buf: a one-entry valid/ready holding register.
  - Inputs: word, wr strobe.
  - Outputs: PDATA, PVALID, plus full/drop indication driving OVERRUN.
  - The FSM, counter and shift register stay in the top.

Test Plan:
- N=7, PREADY=1: send 0xA5 MSB first with SYNC on bit 0, CE=1 throughout → PVALID=1 for exactly one cycle, PDATA=0xA5, on the edge after the 8th bit.
- Same frame with CE low on alternate clocks → PDATA=0xA5 after 16 clks, and BUSY=1 between the first and last bit.
- PREADY=0: send 0x3C then 0xC3 back-to-back → PDATA stays 0x3C, OVERRUN=1 after the second frame; pulse CLR_OVR → OVERRUN=0.
- Send 4 bits of 0xFF, then SYNC with a new 0x12 frame → PDATA=0x12, no spurious word.
- Assert rst after 5 bits → all outputs at reset values immediately; a following full 0x81 frame delivers 0x81.
- With SIPO_PARITY_EN:
  - 0x55 with parity bit 0 → PERR=0;
  - 0x55 with parity bit 1 → PERR=1, PDATA=0x55.
